// File: rtl/led_pkg.sv
// Shared constants, scan phase type and line-decode helpers for the 4x4 LED matrix.
package led_pkg;

    localparam int LED_COUNT = 16;
    localparam int LED_IDX_W = 4;

    localparam logic [3:0] ALED_OFF = 4'b1111;
    localparam logic [3:0] KLED_OFF = 4'b0000;

    // A slot is a blanking interval followed by the PWM interval.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_PWM   = 1'b1
    } scan_phase_t;

    // Anodes are active-low: the selected column drives its line low.
    function automatic logic [3:0] anode_decode(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    // Cathode output-enable is one-hot on the selected row.
    function automatic logic [3:0] cathode_decode(input logic [1:0] row);
        return 4'b0001 << row;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot / tick / blanking counters that walk the matrix one LED slot at a time.
module led_scan_timer
    import led_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter int BRIGHT_W     = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [LED_IDX_W-1:0] o_slot,
    output logic [BRIGHT_W-1:0]  o_tick,
    output logic                 o_in_blank,
    output logic                 o_slot_last,
    output logic                 o_frame_last
);

    localparam int TICK_LAST  = (1 << BRIGHT_W) - 2;
    localparam int DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam scan_phase_t START_PHASE = (BLANK_CYCLES > 0) ? PH_BLANK : PH_PWM;

    scan_phase_t          r_phase;
    scan_phase_t          w_phase_next;
    logic [BLANK_W-1:0]   r_blank_cnt;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [BRIGHT_W-1:0]  r_tick;
    logic [LED_IDX_W-1:0] r_slot;

    logic w_blank_done;
    logic w_tick_done;
    logic w_slot_last;

    assign w_blank_done = (r_phase == PH_BLANK) && (r_blank_cnt == BLANK_W'(BLANK_LAST));
    assign w_tick_done  = (r_phase == PH_PWM) && (r_div_cnt == DIV_W'(TICK_DIV - 1));
    assign w_slot_last  = w_tick_done && (r_tick == BRIGHT_W'(TICK_LAST));

    // Phase register: blanking first, then PWM, back to blanking at slot end.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= START_PHASE;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Next-phase decode.
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            PH_BLANK: if (w_blank_done) w_phase_next = PH_PWM;
            PH_PWM:   if (w_slot_last)  w_phase_next = START_PHASE;
            default:  w_phase_next = START_PHASE;
        endcase
    end

    // Blank, clock-divider, tick and slot counters; each wraps at its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank_cnt <= '0;
            r_div_cnt   <= '0;
            r_tick      <= '0;
            r_slot      <= '0;
        end else begin
            if (r_phase == PH_BLANK) begin
                r_blank_cnt <= w_blank_done ? '0 : r_blank_cnt + 1'b1;
            end
            if (r_phase == PH_PWM) begin
                r_div_cnt <= w_tick_done ? '0 : r_div_cnt + 1'b1;
                if (w_slot_last) begin
                    r_tick <= '0;
                end else if (w_tick_done) begin
                    r_tick <= r_tick + 1'b1;
                end
            end
            if (w_slot_last) begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

    assign o_slot       = r_slot;
    assign o_tick       = r_tick;
    assign o_in_blank   = (r_phase == PH_BLANK);
    assign o_slot_last  = w_slot_last;
    assign o_frame_last = w_slot_last && (r_slot == LED_IDX_W'(LED_COUNT - 1));

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered 4x4 LED frame controller: back-bank writes, frame-aligned
// bank swap, per-slot PWM with blanking, registered anode/cathode drive.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter int BRIGHT_W     = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [LED_IDX_W-1:0] wr_addr,
    input  logic [BRIGHT_W-1:0]  wr_level,
    input  logic                 commit,
    output logic                 swap_pending,
    output logic                 frame_start,
    output logic [3:0]           aled,
    output logic [3:0]           kled_tri
);

    logic [LED_IDX_W-1:0] w_slot;
    logic [BRIGHT_W-1:0]  w_tick;
    logic                 w_in_blank;
    logic                 w_slot_last;
    logic                 w_frame_last;

    led_scan_timer #(
        .TICK_DIV     (TICK_DIV),
        .BRIGHT_W     (BRIGHT_W),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .o_slot       (w_slot),
        .o_tick       (w_tick),
        .o_in_blank   (w_in_blank),
        .o_slot_last  (w_slot_last),
        .o_frame_last (w_frame_last)
    );

    logic [BRIGHT_W-1:0] r_bank [2][LED_COUNT];
    logic                r_front;
    logic                r_swap_pending;
    logic                r_slot_first;
    logic                r_frame_start;
    logic [3:0]          r_aled;
    logic [3:0]          r_kled_tri;

    logic                w_back;
    logic                w_wr_fire;
    logic                w_swap;
    logic [BRIGHT_W-1:0] w_level;
    logic                w_lit;

    assign w_back    = ~r_front;
    assign wr_ready  = ~r_swap_pending;
    assign w_wr_fire = wr_valid && wr_ready;
    // A commit landing on the frame boundary swaps immediately without going pending.
    assign w_swap    = w_frame_last && (r_swap_pending || commit);
    assign w_level   = r_bank[r_front][w_slot];
    assign w_lit     = !w_in_blank && (w_tick < w_level);

    // Bank storage: accepted writes land in the back bank only.
    // NOTE: the banks are cleared by reset because a reset must leave every LED dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < LED_COUNT; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (w_wr_fire) begin
            r_bank[w_back][wr_addr] <= wr_level;
        end
    end

    // Commit tracking and front-bank select, toggled only at a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
        end else if (w_swap) begin
            r_front        <= ~r_front;
            r_swap_pending <= 1'b0;
        end else if (commit) begin
            r_swap_pending <= 1'b1;
        end
    end

    // Output encode, registered one clock after the counter state it decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_first  <= 1'b1;
            r_frame_start <= 1'b0;
            r_aled        <= ALED_OFF;
            r_kled_tri    <= KLED_OFF;
        end else begin
            r_slot_first  <= w_slot_last;
            r_frame_start <= r_slot_first && (w_slot == '0);
            r_aled        <= w_in_blank ? ALED_OFF : anode_decode(w_slot[1:0]);
            r_kled_tri    <= w_lit ? cathode_decode(w_slot[3:2]) : KLED_OFF;
        end
    end

    assign swap_pending = r_swap_pending;
    assign frame_start  = r_frame_start;
    assign aled         = r_aled;
    assign kled_tri     = r_kled_tri;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench: TICK_DIV=1, BRIGHT_W=2, BLANK_CYCLES=1 (slot = 4 clocks, frame = 64).
module tb_led_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_addr = '0;
    logic [1:0] wr_level = '0;
    logic       commit = 1'b0;
    logic       swap_pending;
    logic       frame_start;
    logic [3:0] aled;
    logic [3:0] kled_tri;

    led_frame_scheduler #(
        .TICK_DIV     (1),
        .BRIGHT_W     (2),
        .BLANK_CYCLES (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_level     (wr_level),
        .commit       (commit),
        .swap_pending (swap_pending),
        .frame_start  (frame_start),
        .aled         (aled),
        .kled_tri     (kled_tri)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: two banks, a front select, a pending flag and the
    // position inside the 64-clock frame of the counter state being decoded.
    int m_bank [2][16];
    int m_front;
    bit m_pend;
    int m_count;

    int         obs_p;
    logic [3:0] obs_k;
    logic [3:0] obs_a;
    logic       obs_fs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++)
                m_bank[b][i] = 0;
        m_front = 0;
        m_pend  = 0;
        m_count = 0;
    endtask

    // One clock: drive inputs, predict, advance, compare.
    task automatic step(input logic v, input logic [3:0] a, input logic [1:0] l, input logic c);
        int p, s, ph;
        logic [3:0] ea, ek;
        bit efs, swp;
        wr_valid = v;
        wr_addr  = a;
        wr_level = l;
        commit   = c;
        p  = m_count % 64;
        s  = p / 4;
        ph = p % 4;
        if (ph == 0) begin
            ea = 4'b1111;
            ek = 4'b0000;
        end else begin
            ea = 4'b1111 ^ (4'b0001 << (s % 4));
            ek = ((ph - 1) < m_bank[m_front][s]) ? (4'b0001 << (s / 4)) : 4'b0000;
        end
        efs = (p == 0);
        swp = (p == 63) && (m_pend || c);
        if (v && !m_pend) m_bank[1 - m_front][a] = int'(l);
        if (swp) begin
            m_front = 1 - m_front;
            m_pend  = 0;
        end else if (c) begin
            m_pend = 1;
        end
        m_count++;
        @(posedge clk);
        #1;
        check("aled", aled, ea);
        check("kled_tri", kled_tri, ek);
        check("frame_start", frame_start, efs);
        check("swap_pending", swap_pending, m_pend);
        check("wr_ready", wr_ready, !m_pend);
        obs_p  = p;
        obs_k  = kled_tri;
        obs_a  = aled;
        obs_fs = frame_start;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 2'd0, 1'b0);
    endtask

    // Wait for the next frame_start, then count lit clocks of one slot over that frame.
    task automatic measure_slot(input int addr, input logic [3:0] ek, input logic [3:0] ea,
                                output int lit);
        bit found;
        found = 0;
        lit   = 0;
        for (int i = 0; i < 200; i++) begin
            idle();
            if (obs_fs) begin
                found = 1;
                break;
            end
        end
        check("frame_start_seen", found, 1);
        if (found) begin
            for (int i = 0; i < 64; i++) begin
                if (i > 0) idle();
                if (obs_p / 4 == addr && obs_k != 4'b0000) begin
                    lit++;
                    check("lit_kled", obs_k, ek);
                    check("lit_aled", obs_a, ea);
                end
            end
        end
    endtask

    typedef struct {
        int         addr;
        int         level;
        bit         same_cycle;
        int         exp_lit;
        logic [3:0] exp_k;
        logic [3:0] exp_a;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lit, fs_cnt, lit_cnt;
        bit found;

        vecs[0] = '{addr: 5,  level: 3, same_cycle: 0, exp_lit: 3, exp_k: 4'b0010, exp_a: 4'b1101};
        vecs[1] = '{addr: 10, level: 1, same_cycle: 1, exp_lit: 1, exp_k: 4'b0100, exp_a: 4'b1011};
        vecs[2] = '{addr: 0,  level: 2, same_cycle: 1, exp_lit: 2, exp_k: 4'b0001, exp_a: 4'b1110};
        vecs[3] = '{addr: 15, level: 0, same_cycle: 0, exp_lit: 0, exp_k: 4'b1000, exp_a: 4'b0111};
        vecs[4] = '{addr: 12, level: 3, same_cycle: 1, exp_lit: 3, exp_k: 4'b1000, exp_a: 4'b1110};
        vecs[5] = '{addr: 7,  level: 2, same_cycle: 0, exp_lit: 2, exp_k: 4'b0010, exp_a: 4'b0111};

        // Reset values while rst is held.
        model_reset();
        #12;
        check("rst_aled", aled, 4'b1111);
        check("rst_kled", kled_tri, 4'b0000);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_swap_pending", swap_pending, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Idle frames: nothing lit, frame_start at outputs 0, 64 and 128.
        fs_cnt  = 0;
        lit_cnt = 0;
        for (int i = 0; i < 129; i++) begin
            idle();
            if (obs_fs) fs_cnt++;
            if (obs_k != 4'b0000) lit_cnt++;
        end
        check("idle_frame_starts", fs_cnt, 3);
        check("idle_lit_clocks", lit_cnt, 0);

        // Table: write one LED, commit, check its slot over the next frame.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].same_cycle) begin
                step(1'b1, 4'(vecs[v].addr), 2'(vecs[v].level), 1'b1);
            end else begin
                step(1'b1, 4'(vecs[v].addr), 2'(vecs[v].level), 1'b0);
                step(1'b0, 4'd0, 2'd0, 1'b1);
            end
            measure_slot(vecs[v].addr, vecs[v].exp_k, vecs[v].exp_a, lit);
            check("lit_clocks", lit, vecs[v].exp_lit);
        end

        // Pending blocks writes; a second commit does not cause a second swap.
        step(1'b1, 4'd3, 2'd3, 1'b1);
        check("wr_ready_pending", wr_ready, 1'b0);
        step(1'b1, 4'd3, 2'd1, 1'b1);
        measure_slot(3, 4'b0001, 4'b0111, lit);
        check("blocked_write_lit", lit, 3);
        check("wr_ready_after_swap", wr_ready, 1'b1);
        check("single_swap_pending", swap_pending, 1'b0);

        // Commit exactly on the last cycle of slot 15.
        step(1'b1, 4'd9, 2'd2, 1'b0);
        for (int i = 0; i < 64; i++) begin
            if (m_count % 64 == 63) break;
            idle();
        end
        step(1'b0, 4'd0, 2'd0, 1'b1);
        check("boundary_no_pending", swap_pending, 1'b0);
        measure_slot(9, 4'b0100, 4'b1101, lit);
        check("boundary_lit", lit, 2);

        // Asynchronous reset while an LED is lit.
        step(1'b1, 4'd6, 2'd3, 1'b1);
        measure_slot(6, 4'b0010, 4'b1011, lit);
        check("pre_reset_lit", lit, 3);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            idle();
            if (obs_k != 4'b0000) begin
                found = 1;
                break;
            end
        end
        check("lit_before_reset", found, 1);
        step(1'b0, 4'd0, 2'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_aled", aled, 4'b1111);
        check("async_rst_kled", kled_tri, 4'b0000);
        check("async_rst_pending", swap_pending, 1'b0);
        check("async_rst_wr_ready", wr_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_rst_aled", aled, 4'b1111);
        check("held_rst_kled", kled_tri, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        lit_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            idle();
            if (obs_k != 4'b0000) lit_cnt++;
        end
        check("post_reset_dark", lit_cnt, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
